// File: rtl/demux_2bit_1x4_frame_if.sv
// Bus bundle for the 1:4 frame demultiplexer.
// Inputs (driven by the link/consumer side):
//   en        sample strobe
//   e         incoming WIDTH-bit sample
//   sof       start-of-frame, qualified by en
//   frame_ack consumer acknowledge of the presented frame
// Outputs (driven by the demultiplexer):
//   a, b, c, d   lanes 0..3 of the last completed frame
//   sel          lane pointer for the next accepted sample
//   frame_valid  completed frame presented and not yet acked
//   ovr          sticky overrun flag
//   sync_err     one-cycle pulse when sof arrived mid-frame
interface demux_2bit_1x4_frame_if #(
  parameter int unsigned WIDTH = 2
);
  logic             en;
  logic [WIDTH-1:0] e;
  logic             sof;
  logic             frame_ack;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [1:0]       sel;
  logic             frame_valid;
  logic             ovr;
  logic             sync_err;

  modport master (
    output en, e, sof, frame_ack,
    input  a, b, c, d, sel, frame_valid, ovr, sync_err
  );

  modport slave (
    input  en, e, sof, frame_ack,
    output a, b, c, d, sel, frame_valid, ovr, sync_err
  );
endinterface

// File: rtl/demux_2bit_1x4_frame.sv
// Sequential 1:4 demultiplexer. Consecutive accepted samples are collected into
// shadow registers and the four lanes are published together on the edge that
// accepts the fourth sample, so the consumer never sees a partial frame.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    demux_2bit_1x4_frame_if.slave (en, e, sof, frame_ack in;
//          a, b, c, d, sel, frame_valid, ovr, sync_err out)
module demux_2bit_1x4_frame #(
  parameter int unsigned      WIDTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  demux_2bit_1x4_frame_if.slave   bus
);

  // Pointer states are encoded directly as the sel value.
  typedef enum logic [1:0] {
    Lane0 = 2'd0,
    Lane1 = 2'd1,
    Lane2 = 2'd2,
    Lane3 = 2'd3
  } lane_e;

  lane_e            state_q, state_d;
  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] sh2_q, sh2_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             sync_err_q, sync_err_d;
  logic             complete;

  // sof takes priority over completion: a sof while in Lane3 restarts the frame.
  assign complete = bus.en && !bus.sof && (state_q == Lane3);

  always_comb begin
    state_d    = state_q;
    sh0_d      = sh0_q;
    sh1_d      = sh1_q;
    sh2_d      = sh2_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    d_d        = d_q;
    sync_err_d = 1'b0;

    if (bus.en && bus.sof) begin
      // Restart: partial frame is abandoned, this sample becomes lane 0.
      sh0_d      = bus.e;
      state_d    = Lane1;
      sync_err_d = (state_q != Lane0);
    end else if (bus.en) begin
      unique case (state_q)
        Lane0: begin
          sh0_d   = bus.e;
          state_d = Lane1;
        end
        Lane1: begin
          sh1_d   = bus.e;
          state_d = Lane2;
        end
        Lane2: begin
          sh2_d   = bus.e;
          state_d = Lane3;
        end
        Lane3: begin
          a_d     = sh0_q;
          b_d     = sh1_q;
          c_d     = sh2_q;
          d_d     = bus.e;
          state_d = Lane0;
        end
        default: state_d = Lane0;
      endcase
    end

    if (complete) begin
      valid_d = 1'b1;
    end else if (bus.frame_ack) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    // Overrun: a new frame replaces one the consumer never acknowledged.
    ovr_d = ovr_q || (complete && valid_q && !bus.frame_ack);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= Lane0;
      sh0_q      <= '0;
      sh1_q      <= '0;
      sh2_q      <= '0;
      a_q        <= RESET_VAL;
      b_q        <= RESET_VAL;
      c_q        <= RESET_VAL;
      d_q        <= RESET_VAL;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      sh2_q      <= sh2_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      d_q        <= d_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.c           = c_q;
  assign bus.d           = d_q;
  assign bus.sel         = state_q;
  assign bus.frame_valid = valid_q;
  assign bus.ovr         = ovr_q;
  assign bus.sync_err    = sync_err_q;

endmodule

// File: doc/demux_2bit_1x4_frame.md
Name: demux_2bit_1x4_frame

Overview:
- Sequential 1-to-4 demultiplexer: the receive-side inverse of the 2-bit 4:1 mux.
- Takes a time-division stream of WIDTH-bit samples, one per enabled cycle, and distributes consecutive samples to lanes A, B, C and D.
- Presents the four lanes as a double-buffered frame with a valid/ack handshake.
- Sits at the far end of a link driven by the 4:1 mux swept through select 00, 01, 10, 11.

Parameters:
- WIDTH, 2: bit width of each sample and of each output lane.
- RESET_VAL, 0: value loaded into A, B, C and D on reset.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- EN  input  1  sample strobe; E is accepted on a rising edge where EN=1.
- E  input  WIDTH  incoming sample (the mux output).
- SOF  input  1  start-of-frame; qualified by EN.
- FRAME_ACK  input  1  consumer acknowledge of the presented frame.
- A  output  WIDTH  lane 0 of the last completed frame.
- B  output  WIDTH  lane 1 of the last completed frame.
- C  output  WIDTH  lane 2 of the last completed frame.
- D  output  WIDTH  lane 3 of the last completed frame.
- SEL  output  2  lane pointer for the next accepted sample.
- FRAME_VALID  output  1  a completed frame is presented and not yet acked.
- OVR  output  1  sticky overrun flag.
- SYNC_ERR  output  1  one-cycle pulse: SOF arrived mid-frame.

Behaviour:
- Reset (RST_N=0, asynchronous, takes effect immediately):
  - A, B, C, D = RESET_VAL; SEL=0; FRAME_VALID=0; OVR=0; SYNC_ERR=0.
  - Shadow registers cleared.
  - A reset mid-frame discards the partial frame; a presented frame is dropped.
- Collection. Internal shadow registers SH0..SH2. On an edge with EN=1 and SOF=0:
  - SEL=0..2: SH[SEL] <= E; SEL <= SEL+1.
  - SEL=3 (frame completion): A<=SH0, B<=SH1, C<=SH2, D<=E in the same edge; SEL wraps to 0.
- Output hold:
  - Outputs change only on a completion edge; latency is 1 clock from the 4th sample.
  - The consumer never sees a partially updated frame.
- EN=0: no state change except FRAME_VALID/ACK handling; the pointer holds indefinitely across gaps.
- SOF with EN=1:
  - Sample written to SH0; SEL <= 1.
  - If SEL was nonzero, SYNC_ERR pulses high for exactly the next cycle and the partial frame is discarded.
  - SOF when SEL=0 produces no error.
  - SOF has no effect when EN=0.
- Handshake:
  - FRAME_VALID rises on the completion edge.
  - It falls on the edge where FRAME_ACK=1 and no completion occurs.
  - FRAME_ACK while FRAME_VALID=0 is ignored.
  - Completion and FRAME_ACK on the same edge: FRAME_VALID stays 1, OVR unchanged (old frame consumed, new frame presented).
- Overrun:
  - Applies when a completion edge occurs while FRAME_VALID=1 and FRAME_ACK=0.
  - A..D are overwritten with the new frame, FRAME_VALID stays 1 and OVR <= 1.
  - OVR clears only on reset.
- State machine for the pointer: states LANE0, LANE1, LANE2, LANE3, encoded directly as SEL.
  - LANE0 -> LANE1 -> LANE2 -> LANE3 -> LANE0, advancing on EN.
  - SOF forces the next state to LANE1 from any state.
- Arithmetic: SEL is a 2-bit modulo-4 counter; samples are stored unmodified with no width conversion.

Test Plan:
- Reset: hold RST_N=0, then release.
  - A..D=00, SEL=0, FRAME_VALID=0, OVR=0.
  - Assert RST_N=0 asynchronously mid-cycle: outputs return to 00 before the next edge.
- Basic frame: EN=1, SOF=1 with E=00, then EN=1 with E=01, 10, 11 on the following edges.
  - After the 4th edge: A=00, B=01, C=10, D=11, FRAME_VALID=1, SEL=0, SYNC_ERR never asserted.
- Gapped input: same samples with EN=0 cycles between them.
  - A..D stay RESET_VAL until the edge accepting 11, then update together; SEL holds during the gaps.
- Handshake and overrun:
  - After frame 00/01/10/11, pulse FRAME_ACK: FRAME_VALID=0 next cycle.
  - Second frame 11/10/01/00 completes with FRAME_ACK=0 and completes again: A=11, B=10, C=01, D=00, OVR=1 sticky.
  - Repeat with FRAME_ACK=1 on the completion edge: FRAME_VALID stays 1, OVR stays 0.
- Resync:
  - Send 01, 10 (SEL=2), then SOF with E=11: SYNC_ERR high for one cycle, SEL=1.
  - Continue with 00, 01, 10: frame A=11, B=00, C=01, D=10; the discarded 01, 10 never appear.
- Wrap-around: run 3 back-to-back frames with FRAME_ACK each cycle.
  - SEL cycles 0,1,2,3,0; each frame appears exactly 1 clock after its 4th sample; OVR=0.
